// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix-keypad switch model; closes one commanded key for a commanded number of cycles.
// Latency: keyPadIn follows keyPadOut combinationally while the switch is closed; pressReady/pressDone/scanHits are registered.
// Backpressure: pressReady is high only when idle; a pressValid seen while busy is dropped, never queued.
// Ports: clk, reset (sync, active-high); keyPadOut column drive in / keyPadIn row sense out (active-low, bit3 = index 0);
//   pressValid/pressReady/pressKey/pressHold command handshake; pressDone one-cycle end-of-release pulse; scanHits match count.
// Build option: define KEYPAD_EMU_BOUNCE_EN to add contact bounce windows before and after the hold.
module keypad_emulator #(
  parameter int HOLD_W         = 16,
  parameter int RELEASE_CYCLES = 8,
  parameter int BOUNCE_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        keyPadOut,
  output logic [3:0]        keyPadIn,
  input  logic              pressValid,
  output logic              pressReady,
  input  logic [3:0]        pressKey,
  input  logic [HOLD_W-1:0] pressHold,
  output logic              pressDone,
  output logic [7:0]        scanHits
);

  localparam int GAP_W = $clog2(RELEASE_CYCLES + 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BNC_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HOLD       = 3'd1,
    S_GAP        = 3'd2
`ifdef KEYPAD_EMU_BOUNCE_EN
    , S_BOUNCE_ON  = 3'd3,
    S_BOUNCE_OFF = 3'd4
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        key_q, key_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]        hits_q, hits_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [BNC_W-1:0]  bounce_cnt_q, bounce_cnt_d;
`endif

  logic [3:0] col_pat;
  logic [3:0] row_pat;
  logic       col_match;
  logic       transfer;
  logic       switch_closed;

  // Active-low one-hot patterns for the latched key; bit3 is index 0.
  assign col_pat   = ~(4'b1000 >> key_q[3:2]);
  assign row_pat   = ~(4'b1000 >> key_q[1:0]);
  // col_pat always has exactly one low bit, so non-one-hot drives can never match.
  assign col_match = (keyPadOut == col_pat);
  assign transfer  = pressValid & ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      hits_q       <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bounce_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      hits_q       <= hits_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bounce_cnt_q <= bounce_cnt_d;
`endif
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    hits_d     = hits_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    bounce_cnt_d = bounce_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          key_d      = pressKey;
          // Counts down to 1, so a zero request still gets one hold cycle and all-ones never wraps.
          hold_cnt_d = (pressHold == '0) ? HOLD_W'(1) : pressHold;
          hits_d     = '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
          bounce_cnt_d = '0;
          state_d      = S_BOUNCE_ON;
`else
          state_d      = S_HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      S_BOUNCE_ON: begin
        if (bounce_cnt_q == BNC_W'(BOUNCE_CYCLES - 1)) begin
          bounce_cnt_d = '0;
          state_d      = S_HOLD;
        end else begin
          bounce_cnt_d = bounce_cnt_q + 1'b1;
        end
      end
`endif
      S_HOLD: begin
        if (col_match && (hits_q != 8'hFF)) hits_d = hits_q + 8'd1;
        if (hold_cnt_q == HOLD_W'(1)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          bounce_cnt_d = '0;
          state_d      = S_BOUNCE_OFF;
`else
          gap_cnt_d    = GAP_W'(RELEASE_CYCLES);
          state_d      = S_GAP;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      S_BOUNCE_OFF: begin
        if (bounce_cnt_q == BNC_W'(BOUNCE_CYCLES - 1)) begin
          gap_cnt_d = GAP_W'(RELEASE_CYCLES);
          state_d   = S_GAP;
        end else begin
          bounce_cnt_d = bounce_cnt_q + 1'b1;
        end
      end
`endif
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) state_d = S_IDLE;
        else                        gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    // Registered pulse lands in the final GAP cycle.
    done_d  = (state_d == S_GAP) && (gap_cnt_d == GAP_W'(1));
  end

  // Outputs
  always_comb begin
    switch_closed = (state_q == S_HOLD);
`ifdef KEYPAD_EMU_BOUNCE_EN
    // Contact chatters: closed on even bounce counts, open on odd.
    if (((state_q == S_BOUNCE_ON) || (state_q == S_BOUNCE_OFF)) && !bounce_cnt_q[0])
      switch_closed = 1'b1;
`endif
    keyPadIn   = (switch_closed && col_match) ? row_pat : 4'b1111;
    pressReady = ready_q;
    pressDone  = done_q;
    scanHits   = hits_q;
  end

endmodule
